// File: rtl/es_pkg.sv
// Shared types and constants for the es_responder IN/OUT device responder.
package es_pkg;

    typedef enum logic [1:0] {
        OCIOSO,
        ESPERA_DIGITO,
        CONVERTE,
        CONCLUI
    } state_t;

    localparam logic [3:0] KEY_ENTER      = 4'hF;
    localparam int         MAX_DEC        = 999;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;

    // Double-dabble correction applied to one BCD nibble before each shift.
    function automatic logic [3:0] bcd_adj(input logic [3:0] n);
        return (n >= BCD_ADJ_THRESH) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/es_responder_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one bit per cycle, three BCD digits.
module bin2bcd_seq
    import es_pkg::*;
#(
    parameter int BIN_W = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic             done_o,
    output logic [3:0]       uni_o,
    output logic [3:0]       dez_o,
    output logic [3:0]       cen_o
);
    localparam int CW = $clog2(BIN_W + 1);

    logic [BIN_W-1:0] sh_q, sh_d;
    logic [11:0]      bcd_q, bcd_d, adj;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        adj   = {bcd_adj(bcd_q[11:8]), bcd_adj(bcd_q[7:4]), bcd_adj(bcd_q[3:0])};
        sh_d  = sh_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        if (start_i) begin
            sh_d  = bin_i;
            bcd_d = '0;
            cnt_d = CW'(BIN_W);
        end else if (cnt_q != '0) begin
            {bcd_d, sh_d} = {adj[10:0], sh_q, 1'b0};
            cnt_d         = cnt_q - 1'b1;
        end
    end

    // done_o flags the edge that performs the last iteration; digits are the
    // post-edge value so the caller can capture them on that same edge.
    assign done_o = (cnt_q == CW'(1));
    assign uni_o  = bcd_d[3:0];
    assign dez_o  = bcd_d[7:4];
    assign cen_o  = bcd_d[11:8];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_q  <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/es_responder.sv
// Device-side responder for CPU IN/OUT: decimal digit entry from switches, BCD display of OUT values.
// Optional macro ECO_DISPLAY_EN: echo entered digits on the display while waiting for input.
module es_responder
    import es_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BIN_W  = 10,
    parameter int DIGITS = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_in,
    input  logic              req_out,
    input  logic [DATA_W-1:0] dado_out,
    input  logic              botao,
    input  logic [3:0]        chaves,
    output logic [DATA_W-1:0] dado_in,
    output logic              pronto,
    output logic              ocupado,
    output logic [3:0]        unidade,
    output logic [3:0]        dezena,
    output logic [3:0]        centena,
    output logic              erro
);
    localparam int CNT_W = $clog2(DIGITS + 1);

    state_t            st_q, st_d;
    logic              botao_q, press, over_max;
    logic [BIN_W-1:0]  acc_q, acc_d, acc_nxt, conv_bin;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              erro_q, erro_d;
    logic [3:0]        uni_q, uni_d, dez_q, dez_d, cen_q, cen_d;
    logic              conv_start, conv_done;
    logic [3:0]        conv_uni, conv_dez, conv_cen;

    assign press    = botao & ~botao_q;
    assign over_max = (dado_out > DATA_W'(MAX_DEC));
    assign conv_bin = over_max ? BIN_W'(MAX_DEC) : dado_out[BIN_W-1:0];
    assign acc_nxt  = (acc_q << 3) + (acc_q << 1) + BIN_W'(chaves);

    bin2bcd_seq #(.BIN_W(BIN_W)) u_conv (
        .clk_i  (clock),
        .rst_ni (reset),
        .start_i(conv_start),
        .bin_i  (conv_bin),
        .done_o (conv_done),
        .uni_o  (conv_uni),
        .dez_o  (conv_dez),
        .cen_o  (conv_cen)
    );

    always_comb begin
        st_d       = st_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        din_d      = din_q;
        erro_d     = erro_q;
        uni_d      = uni_q;
        dez_d      = dez_q;
        cen_d      = cen_q;
        conv_start = 1'b0;
        case (st_q)
            OCIOSO: begin
                // OUT wins a same-cycle collision; the dropped IN is flagged.
                if (req_out) begin
                    conv_start = 1'b1;
                    erro_d     = req_in | over_max;
                    st_d       = CONVERTE;
                end else if (req_in) begin
                    acc_d  = '0;
                    cnt_d  = '0;
                    erro_d = 1'b0;
                    st_d   = ESPERA_DIGITO;
`ifdef ECO_DISPLAY_EN
                    uni_d = '0;
                    dez_d = '0;
                    cen_d = '0;
`endif
                end
            end
            ESPERA_DIGITO: begin
                if (press) begin
                    if (chaves <= 4'd9) begin
                        acc_d = acc_nxt;
                        cnt_d = cnt_q + 1'b1;
`ifdef ECO_DISPLAY_EN
                        cen_d = dez_q;
                        dez_d = uni_q;
                        uni_d = chaves;
`endif
                        if (cnt_q + 1'b1 == CNT_W'(DIGITS)) begin
                            din_d = DATA_W'(acc_nxt);
                            st_d  = CONCLUI;
                        end
                    end else if (chaves == KEY_ENTER) begin
                        if (cnt_q != '0) begin
                            din_d = DATA_W'(acc_q);
                            st_d  = CONCLUI;
                        end
                    end else begin
                        erro_d = 1'b1;
                    end
                end
            end
            CONVERTE: begin
                if (conv_done) begin
                    uni_d = conv_uni;
                    dez_d = conv_dez;
                    cen_d = conv_cen;
                    st_d  = CONCLUI;
                end
            end
            CONCLUI: st_d = OCIOSO;
            default: st_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st_q    <= OCIOSO;
            botao_q <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            din_q   <= '0;
            erro_q  <= 1'b0;
            uni_q   <= '0;
            dez_q   <= '0;
            cen_q   <= '0;
        end else begin
            st_q    <= st_d;
            botao_q <= botao;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            erro_q  <= erro_d;
            uni_q   <= uni_d;
            dez_q   <= dez_d;
            cen_q   <= cen_d;
        end
    end

    assign dado_in = din_q;
    assign pronto  = (st_q == CONCLUI);
    assign ocupado = (st_q != OCIOSO);
    assign unidade = uni_q;
    assign dezena  = dez_q;
    assign centena = cen_q;
    assign erro    = erro_q;

endmodule

// File: tb/tb_es_responder.sv
// Directed, table-driven bench for es_responder (IN digit entry, OUT BCD display, reset abort).
module tb_es_responder;
    logic        clock = 1'b0, reset = 1'b0, req_in = 1'b0, req_out = 1'b0, botao = 1'b0;
    logic [31:0] dado_out = '0;
    logic [3:0]  chaves = '0;
    logic [31:0] dado_in;
    logic        pronto, ocupado, erro;
    logic [3:0]  unidade, dezena, centena;

    int          n_run = 0, n_fail = 0;
    logic [11:0] m_disp = '0;
    logic [31:0] m_din = '0;

    typedef struct {
        bit          is_out;
        logic [31:0] val;
        int          n;
        logic [15:0] keys;
        logic [31:0] exp_din;
        logic [11:0] exp_disp;
        bit          exp_err;
    } vec_t;

    es_responder #(.DATA_W(32), .BIN_W(10), .DIGITS(3)) dut (
        .clock(clock), .reset(reset), .req_in(req_in), .req_out(req_out),
        .dado_out(dado_out), .botao(botao), .chaves(chaves), .dado_in(dado_in),
        .pronto(pronto), .ocupado(ocupado), .unidade(unidade), .dezena(dezena),
        .centena(centena), .erro(erro)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic logic [31:0] disp();
        return {20'd0, centena, dezena, unidade};
    endfunction

    task automatic run_out(input logic [31:0] v, input bit both, input bit poke,
                           input logic [11:0] exp_d, input bit exp_e);
        int lat;
        bit stable;
        lat      = 0;
        stable   = 1'b1;
        dado_out = v;
        req_out  = 1'b1;
        req_in   = both;
        do begin
            @(posedge clock); #1;
            lat++;
            req_out = 1'b0;
            req_in  = poke && (lat == 3);
            if (!pronto && disp() != {20'd0, m_disp}) stable = 1'b0;
        end while (!pronto && lat < 30);
        req_in = 1'b0;
        chk("out_latency", 32'(lat), 32'd11);
        chk("out_display", disp(), {20'd0, exp_d});
        chk("out_erro", {31'd0, erro}, {31'd0, exp_e});
        chk("out_dado_in_held", dado_in, m_din);
        chk("out_display_stable", {31'd0, stable}, 32'd1);
        @(posedge clock); #1;
        chk("out_idle_after", {30'd0, ocupado, pronto}, 32'd0);
        m_disp = exp_d;
    endtask

    task automatic run_in(input int n, input logic [15:0] keys, input logic [31:0] exp_din,
                          input bit exp_e);
        int         pr_at;
        logic [3:0] k;
        pr_at  = -1;
        req_in = 1'b1;
        @(posedge clock); #1;
        req_in = 1'b0;
        chk("in_busy", {31'd0, ocupado}, 32'd1);
`ifdef ECO_DISPLAY_EN
        m_disp = '0;
`endif
        for (int i = 0; i < n; i++) begin
            k      = keys[4*i +: 4];
            chaves = k;
            botao  = 1'b1;
            @(posedge clock); #1;
            if (pronto && pr_at < 0) begin
                pr_at = i;
                chk("in_dado_in_at_pronto", dado_in, exp_din);
            end
`ifdef ECO_DISPLAY_EN
            if (k <= 4'd9) m_disp = {m_disp[7:0], k};
`endif
            botao = 1'b0;
            @(posedge clock); #1;
        end
        chk("in_pronto_position", 32'(pr_at), 32'(n - 1));
        chk("in_dado_in_held", dado_in, exp_din);
        chk("in_erro", {31'd0, erro}, {31'd0, exp_e});
        chk("in_display", disp(), {20'd0, m_disp});
        chk("in_idle_after", {30'd0, ocupado, pronto}, 32'd0);
        m_din = exp_din;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tv[12];
        tv[0]  = '{1'b0, 32'd0,    3, 16'h0321, 32'd123, 12'h000, 1'b0};
        tv[1]  = '{1'b0, 32'd0,    2, 16'h00F4, 32'd4,   12'h000, 1'b0};
        tv[2]  = '{1'b0, 32'd0,    3, 16'h0F7F, 32'd7,   12'h000, 1'b0};
        tv[3]  = '{1'b0, 32'd0,    3, 16'h0F5A, 32'd5,   12'h000, 1'b1};
        tv[4]  = '{1'b1, 32'd57,   0, 16'h0000, 32'd0,   12'h057, 1'b0};
        tv[5]  = '{1'b1, 32'd1500, 0, 16'h0000, 32'd0,   12'h999, 1'b1};
        tv[6]  = '{1'b0, 32'd0,    3, 16'h0999, 32'd999, 12'h000, 1'b0};
        tv[7]  = '{1'b1, 32'd0,    0, 16'h0000, 32'd0,   12'h000, 1'b0};
        tv[8]  = '{1'b0, 32'd0,    3, 16'h0F13, 32'd31,  12'h000, 1'b0};
        tv[9]  = '{1'b1, 32'd842,  0, 16'h0000, 32'd0,   12'h842, 1'b0};
        tv[10] = '{1'b1, 32'd999,  0, 16'h0000, 32'd0,   12'h999, 1'b0};
        tv[11] = '{1'b1, 32'd1000, 0, 16'h0000, 32'd0,   12'h999, 1'b1};

        repeat (2) @(posedge clock);
        #1;
        chk("rst_dado_in", dado_in, 32'd0);
        chk("rst_pronto_ocupado", {30'd0, ocupado, pronto}, 32'd0);
        chk("rst_display", disp(), 32'd0);
        chk("rst_erro", {31'd0, erro}, 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 12; i++) begin
            if (tv[i].is_out) run_out(tv[i].val, 1'b0, 1'b0, tv[i].exp_disp, tv[i].exp_err);
            else              run_in(tv[i].n, tv[i].keys, tv[i].exp_din, tv[i].exp_err);
        end

        // IN request while converting is dropped silently.
        run_out(32'd305, 1'b0, 1'b1, 12'h305, 1'b0);
        // Simultaneous IN+OUT: OUT serviced, collision flagged.
        run_out(32'd25, 1'b1, 1'b0, 12'h025, 1'b1);

        // Reset mid-conversion clears everything asynchronously.
        dado_out = 32'd842;
        req_out  = 1'b1;
        @(posedge clock); #1;
        req_out = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_display", disp(), 32'd0);
        chk("midrst_pronto_ocupado", {30'd0, ocupado, pronto}, 32'd0);
        chk("midrst_erro", {31'd0, erro}, 32'd0);
        chk("midrst_dado_in", dado_in, 32'd0);
        m_disp = '0;
        m_din  = '0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        run_in(2, 16'h00F6, 32'd6, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
